// File: rtl/painterengine_gpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | painterengine_gpu_pkg: shared sizing helpers and defaults for GPU FIFOs    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package painterengine_gpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_DEPTH = 64;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // One extra bit so an occupancy of exactly DEPTH is representable.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage : painterengine_gpu_pkg
`default_nettype wire

// File: rtl/painterengine_gpu_fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | painterengine_gpu_fifo_ram: synchronous-write, asynchronous-read storage  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module painterengine_gpu_fifo_ram
  import painterengine_gpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_WIDTH,
  parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read gives the fall-through head in the same cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule : painterengine_gpu_fifo_ram
`default_nettype wire

// File: rtl/painterengine_gpu_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | painterengine_gpu_sync_fifo: single-clock FWFT FIFO with valid/ready,     |
// | programmable thresholds, flush. Optional PAINTERENGINE_GPU_FIFO_ERRFLAG_EN|
// | enables sticky overflow/underflow flags. Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module painterengine_gpu_sync_fifo
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PARAM_FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int ADDR_W  = clog2(PARAM_FIFO_DEPTH),
  localparam int COUNT_W = count_width(PARAM_FIFO_DEPTH)
) (
  input  logic                        i_wire_clock,
  input  logic                        i_wire_resetn,
  input  logic                        i_wire_flush,
  input  logic                        i_wire_write_valid,
  output logic                        o_wire_write_ready,
  input  logic [PARAM_DATA_WIDTH-1:0] i_wire_data_in,
  output logic                        o_wire_read_valid,
  input  logic                        i_wire_read_ready,
  output logic [PARAM_DATA_WIDTH-1:0] o_wire_data_out,
  input  logic [COUNT_W-1:0]          i_wire_almost_full_level,
  input  logic [COUNT_W-1:0]          i_wire_almost_empty_level,
  output logic                        o_wire_full,
  output logic                        o_wire_empty,
  output logic                        o_wire_almost_full,
  output logic                        o_wire_almost_empty,
  output logic [COUNT_W-1:0]          o_wire_data_count,
  output logic [COUNT_W-1:0]          o_wire_empty_count,
  output logic                        o_wire_overflow,
  output logic                        o_wire_underflow
);

  localparam logic [COUNT_W-1:0] DEPTH_VAL = COUNT_W'(PARAM_FIFO_DEPTH);
  localparam logic [COUNT_W-1:0] ONE_VAL   = COUNT_W'(1);

  logic [COUNT_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [COUNT_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]          count_q, count_d;
  logic                        full_w, empty_w;
  logic                        push_w, pop_w;
  logic [PARAM_DATA_WIDTH-1:0] ram_rdata_w;

  assign full_w  = (count_q == DEPTH_VAL);
  assign empty_w = (count_q == '0);

  // Handshake qualification; flush overrides both transfers.
  assign push_w = i_wire_write_valid && !full_w && !i_wire_flush;
  assign pop_w  = i_wire_read_ready && !empty_w && !i_wire_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_wire_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + ONE_VAL;
      end
      if (pop_w) begin
        rd_ptr_d = rd_ptr_q + ONE_VAL;
      end
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + ONE_VAL;
        2'b01:   count_d = count_q - ONE_VAL;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  painterengine_gpu_fifo_ram #(
    .DATA_W (PARAM_DATA_WIDTH),
    .DEPTH  (PARAM_FIFO_DEPTH)
  ) u_ram (
    .clk_i   (i_wire_clock),
    .we_i    (push_w),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (i_wire_data_in),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata_w)
  );

  assign o_wire_write_ready  = !full_w;
  assign o_wire_read_valid   = !empty_w;
  assign o_wire_data_out     = empty_w ? '0 : ram_rdata_w;
  assign o_wire_full         = full_w;
  assign o_wire_empty        = empty_w;
  assign o_wire_almost_full  = (count_q >= i_wire_almost_full_level);
  assign o_wire_almost_empty = (count_q <= i_wire_almost_empty_level);
  assign o_wire_data_count   = count_q;
  assign o_wire_empty_count  = DEPTH_VAL - count_q;

`ifdef PAINTERENGINE_GPU_FIFO_ERRFLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_wire_flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (i_wire_write_valid && full_w) begin
        overflow_d = 1'b1;
      end
      if (i_wire_read_ready && empty_w) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_wire_overflow  = overflow_q;
  assign o_wire_underflow = underflow_q;
`else
  assign o_wire_overflow  = 1'b0;
  assign o_wire_underflow = 1'b0;
`endif

endmodule : painterengine_gpu_sync_fifo
`default_nettype wire

// File: tb/tb_painterengine_gpu_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_painterengine_gpu_sync_fifo: directed scoreboard bench, DEPTH=4, W=8   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_painterengine_gpu_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef PAINTERENGINE_GPU_FIFO_ERRFLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wv;
  logic          wready;
  logic [DW-1:0] din;
  logic          rvalid;
  logic          rr;
  logic [DW-1:0] dout;
  logic [CW-1:0] af_lvl;
  logic [CW-1:0] ae_lvl;
  logic          full, empty, afull, aempty;
  logic [CW-1:0] dcount, ecount;
  logic          ovf, unf;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  painterengine_gpu_sync_fifo #(
    .PARAM_DATA_WIDTH (DW),
    .PARAM_FIFO_DEPTH (DEPTH)
  ) dut (
    .i_wire_clock              (clk),
    .i_wire_resetn             (rst_n),
    .i_wire_flush              (flush),
    .i_wire_write_valid        (wv),
    .o_wire_write_ready        (wready),
    .i_wire_data_in            (din),
    .o_wire_read_valid         (rvalid),
    .i_wire_read_ready         (rr),
    .o_wire_data_out           (dout),
    .i_wire_almost_full_level  (af_lvl),
    .i_wire_almost_empty_level (ae_lvl),
    .o_wire_full               (full),
    .o_wire_empty              (empty),
    .o_wire_almost_full        (afull),
    .o_wire_almost_empty       (aempty),
    .o_wire_data_count         (dcount),
    .o_wire_empty_count        (ecount),
    .o_wire_overflow           (ovf),
    .o_wire_underflow          (unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop must present the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && !flush && rvalid && rr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no output", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pop_data", {24'h0, dout}, {24'h0, mon_exp});
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    wv     = 1'b0;
    rr     = 1'b0;
    din    = '0;
    af_lvl = '0;
    ae_lvl = '0;
    step();
    step();

    // Reset state; almost_full follows a zero threshold.
    chk("rst_empty",       empty,  1);
    chk("rst_full",        full,   0);
    chk("rst_write_ready", wready, 1);
    chk("rst_read_valid",  rvalid, 0);
    chk("rst_count",       dcount, 0);
    chk("rst_empty_count", ecount, 4);
    chk("rst_data_out",    dout,   0);
    chk("rst_almost_full", afull,  1);
    chk("rst_almost_empty",aempty, 1);
    chk("rst_overflow",    ovf,    0);
    chk("rst_underflow",   unf,    0);
    af_lvl = 3'd4;
    #1;
    chk("af_level_4_count_0", afull, 0);
    rst_n = 1'b1;
    step();

    // Fill and block.
    for (int i = 0; i < 4; i++) begin
      wv  = 1'b1;
      din = 8'hA0 + 8'(i);
      exp_q.push_back(din);
      step();
    end
    chk("fill_full",        full,   1);
    chk("fill_write_ready", wready, 0);
    chk("fill_count",       dcount, 4);
    chk("fill_empty_count", ecount, 0);
    chk("fill_head",        dout,   8'hA0);
    din = 8'hEE;
    step();
    wv = 1'b0;
    chk("blocked_count",    dcount, 4);
    chk("overflow_flag",    ovf,    ERR_EN);

    // Drain in order.
    rr = 1'b1;
    repeat (4) step();
    rr = 1'b0;
    chk("drain_empty",      empty,  1);
    chk("drain_read_valid", rvalid, 0);
    chk("drain_data_out",   dout,   0);
    chk("drain_no_underflow", unf,  0);

    // Simultaneous push/pop across the pointer wrap.
    for (int k = 0; k < 6; k++) begin
      wv  = 1'b1;
      din = 8'hB0 + 8'(k);
      rr  = (k != 0);
      exp_q.push_back(din);
      step();
      chk("wrap_count", dcount, 1);
    end
    wv = 1'b0;
    rr = 1'b1;
    step();
    rr = 1'b0;
    chk("wrap_empty",      empty,  1);
    chk("wrap_underflow",  unf,    0);
    chk("overflow_sticky", ovf,    ERR_EN);

    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clears_overflow", ovf, 0);

    // Thresholds.
    af_lvl = 3'd3;
    ae_lvl = 3'd1;
    #1;
    chk("thr0_afull",  afull,  0);
    chk("thr0_aempty", aempty, 1);
    wv = 1'b1;
    din = 8'hC0; exp_q.push_back(din); step();
    chk("thr1_afull",  afull,  0);
    chk("thr1_aempty", aempty, 1);
    din = 8'hC1; exp_q.push_back(din); step();
    chk("thr2_afull",  afull,  0);
    chk("thr2_aempty", aempty, 0);
    din = 8'hC2; exp_q.push_back(din); step();
    wv = 1'b0;
    chk("thr3_afull",  afull,  1);
    chk("thr3_aempty", aempty, 0);
    af_lvl = 3'd4;
    #1;
    chk("thr_live_change", afull, 0);

    // Flush with a concurrent push at count 2.
    rr = 1'b1;
    step();
    rr = 1'b0;
    chk("preflush_count", dcount, 2);
    flush = 1'b1;
    wv    = 1'b1;
    din   = 8'hDD;
    step();
    flush = 1'b0;
    wv    = 1'b0;
    exp_q.delete();
    chk("flush_count",      dcount, 0);
    chk("flush_empty",      empty,  1);
    chk("flush_read_valid", rvalid, 0);
    wv = 1'b1;
    din = 8'hE0; exp_q.push_back(din); step();
    wv = 1'b0;
    chk("postflush_count", dcount, 1);
    rr = 1'b1;
    step();

    // Underflow: read_ready stays high while empty.
    step();
    chk("underflow_set",    unf,    ERR_EN);
    chk("underflow_rvalid", rvalid, 0);
    rr = 1'b0;
    step();
    chk("underflow_sticky", unf,    ERR_EN);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("underflow_cleared", unf, 0);

    // Asynchronous reset in the middle of a push.
    wv = 1'b1;
    din = 8'hF0; exp_q.push_back(din); step();
    din = 8'hF1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    wv = 1'b0;
    chk("midrst_count", dcount, 0);
    chk("midrst_empty", empty,  1);
    chk("midrst_dout",  dout,   0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_count", dcount, 0);
    wv = 1'b1;
    din = 8'h5A; exp_q.push_back(din); step();
    wv = 1'b0;
    rr = 1'b1;
    step();
    rr = 1'b0;
    step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_painterengine_gpu_sync_fifo
`default_nettype wire
